// File: rtl/axi_rd_pkg.sv
// Shared types and AXI encodings for the AXI4 read burst master.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rd_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: on a stage_start rising edge it fetches ROW_NUM rows of
// WORDS_PER_ROW words in fixed-length INCR bursts, one burst outstanding, and
// forwards every accepted R beat to the downstream serial-to-BRAM stage.
module axi_rd_burst_master
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int BURST_LEN     = 16,
    parameter int WORDS_PER_ROW = 384,
    parameter int ROW_NUM       = 64
) (
    input  logic              axi_ACLK,
    input  logic              axi_ARESETN,
    input  logic              stage_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] axi_ARADDR,
    output logic [7:0]        axi_ARLEN,
    output logic [2:0]        axi_ARSIZE,
    output logic [1:0]        axi_ARBURST,
    output logic              axi_ARVALID,
    input  logic              axi_ARREADY,
    input  logic [31:0]       axi_RDATA,
    input  logic [1:0]        axi_RRESP,
    input  logic              axi_RLAST,
    input  logic              axi_RVALID,
    output logic              axi_RREADY,
    output logic [31:0]       out_rdata,
    output logic              out_rlast,
    output logic              out_shake,
    output logic              stage_busy,
    output logic              stage_done,
    output logic              rd_error
);

    // Bursts per row and counter widths (at least one bit each so degenerate
    // parameter choices still elaborate).
    localparam int BURSTS_PER_ROW = WORDS_PER_ROW / BURST_LEN;
    localparam int BEAT_W  = (BURST_LEN > 1)      ? $clog2(BURST_LEN)      : 1;
    localparam int BURST_W = (BURSTS_PER_ROW > 1) ? $clog2(BURSTS_PER_ROW) : 1;
    localparam int ROW_W   = (ROW_NUM > 1)        ? $clog2(ROW_NUM)        : 1;

    localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(BURSTS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(ROW_NUM - 1);
    localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * 4);
    // Clears the low six address bits so every fetch starts 64-byte aligned.
    localparam logic [ADDR_W-1:0]  ALIGN_MASK  = ~ADDR_W'(63);

    // A row must split into a whole number of bursts, and ARLEN is 8 bits.
    generate
        if (WORDS_PER_ROW % BURST_LEN != 0) begin : g_bad_words_per_row
            $error("axi_rd_burst_master: WORDS_PER_ROW must be a multiple of BURST_LEN");
        end
        if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
            $error("axi_rd_burst_master: BURST_LEN must be in 1..256");
        end
    endgenerate

    rd_state_t           state;
    logic                start_ff;
    logic                go;
    logic                beat_hs;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic [ROW_W-1:0]    row_cnt;

    assign go      = stage_start & ~start_ff;
    assign beat_hs = axi_RVALID & axi_RREADY;

    assign axi_ARLEN   = 8'(BURST_LEN - 1);
    assign axi_ARSIZE  = AXI_SIZE_4B;
    assign axi_ARBURST = AXI_BURST_INCR;

    assign out_rdata = axi_RDATA;
    assign out_rlast = axi_RLAST;
    assign out_shake = beat_hs;

    // Remember last cycle's stage_start level so only a rising edge starts a fetch.
    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            start_ff <= 1'b0;
        end else begin
            start_ff <= stage_start;
        end
    end

    // Fetch sequencer: issues one burst address, drains its beats, advances the
    // burst/row counters, and pulses stage_done after the final beat.
    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            state       <= IDLE;
            axi_ARADDR  <= '0;
            axi_ARVALID <= 1'b0;
            axi_RREADY  <= 1'b0;
            stage_busy  <= 1'b0;
            stage_done  <= 1'b0;
            rd_error    <= 1'b0;
            beat_cnt    <= '0;
            burst_cnt   <= '0;
            row_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stage_done <= 1'b0;
                    if (go) begin
                        state       <= ADDR;
                        axi_ARADDR  <= base_addr & ALIGN_MASK;
                        axi_ARVALID <= 1'b1;
                        stage_busy  <= 1'b1;
                        rd_error    <= 1'b0;
                        beat_cnt    <= '0;
                        burst_cnt   <= '0;
                        row_cnt     <= '0;
                    end
                end

                ADDR: begin
                    if (axi_ARVALID && axi_ARREADY) begin
                        state       <= DATA;
                        axi_ARVALID <= 1'b0;
                        axi_RREADY  <= 1'b1;
                    end
                end

                DATA: begin
                    if (beat_hs) begin
                        if (axi_RRESP != AXI_RESP_OKAY) begin
                            rd_error <= 1'b1;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            if (!axi_RLAST) begin
                                rd_error <= 1'b1;
                            end
                            beat_cnt   <= '0;
                            axi_ARADDR <= axi_ARADDR + BURST_BYTES;
                            axi_RREADY <= 1'b0;
                            if (burst_cnt == LAST_BURST) begin
                                burst_cnt <= '0;
                                row_cnt   <= row_cnt + ROW_W'(1);
                            end else begin
                                burst_cnt <= burst_cnt + BURST_W'(1);
                            end
                            if (burst_cnt == LAST_BURST && row_cnt == LAST_ROW) begin
                                state      <= DONE;
                                stage_done <= 1'b1;
                            end else begin
                                state       <= ADDR;
                                axi_ARVALID <= 1'b1;
                            end
                        end else begin
                            if (axi_RLAST) begin
                                rd_error <= 1'b1;
                            end
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end

                DONE: begin
                    stage_done <= 1'b0;
                    stage_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Self-checking bench for axi_rd_burst_master: a behavioural AXI slave that
// scoreboards expected burst addresses and read beats, plus scenario tasks.
module tb_axi_rd_burst_master;

    localparam int BL     = 16;
    localparam int WPR    = 32;
    localparam int ROWS   = 2;
    localparam int BURSTS = (WPR / BL) * ROWS;
    localparam int BEATS  = WPR * ROWS;

    logic        axi_ACLK    = 1'b0;
    logic        axi_ARESETN = 1'b0;
    logic        stage_start = 1'b0;
    logic [31:0] base_addr   = '0;
    logic [31:0] axi_ARADDR;
    logic [7:0]  axi_ARLEN;
    logic [2:0]  axi_ARSIZE;
    logic [1:0]  axi_ARBURST;
    logic        axi_ARVALID;
    logic        axi_ARREADY = 1'b0;
    logic [31:0] axi_RDATA   = '0;
    logic [1:0]  axi_RRESP   = '0;
    logic        axi_RLAST   = 1'b0;
    logic        axi_RVALID  = 1'b0;
    logic        axi_RREADY;
    logic [31:0] out_rdata;
    logic        out_rlast;
    logic        out_shake;
    logic        stage_busy;
    logic        stage_done;
    logic        rd_error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_ar[$];
    logic [32:0] exp_r[$];

    int arready_delay = 0;
    bit gap_mode      = 1'b0;
    int err_beat      = -1;
    int rlast_early   = -1;

    int ar_count, shake_count, done_count, run_beat, r_burst, beat_idx;
    int ar_wait, ar_viol, shake_viol, err_drop;
    int cyc, last_beat_cyc, done_cyc;
    bit r_active, beat_pushed, ar_waiting, gap_phase, prev_err, prev_busy;
    logic [31:0] ar_hold_addr, cur_data, exp_addr;
    logic [32:0] exp_beat;
    logic        cur_last;
    logic [1:0]  cur_resp;

    axi_rd_burst_master #(
        .ADDR_W(32), .BURST_LEN(BL), .WORDS_PER_ROW(WPR), .ROW_NUM(ROWS)
    ) dut (
        .axi_ACLK(axi_ACLK), .axi_ARESETN(axi_ARESETN),
        .stage_start(stage_start), .base_addr(base_addr),
        .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN), .axi_ARSIZE(axi_ARSIZE),
        .axi_ARBURST(axi_ARBURST), .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY),
        .axi_RDATA(axi_RDATA), .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST),
        .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY),
        .out_rdata(out_rdata), .out_rlast(out_rlast), .out_shake(out_shake),
        .stage_busy(stage_busy), .stage_done(stage_done), .rd_error(rd_error)
    );

    always #5 axi_ACLK = ~axi_ACLK;

    // Slave model and monitor: drive on the falling edge, sample 1 ns later,
    // and account for the handshakes the next rising edge will take.
    initial begin
        forever begin
            @(negedge axi_ACLK);
            if (!axi_ARESETN) begin
                r_active = 0; beat_pushed = 0; ar_waiting = 0; ar_wait = 0; gap_phase = 0;
                exp_ar.delete(); exp_r.delete();
                axi_ARREADY = 0; axi_RVALID = 0; axi_RLAST = 0; axi_RRESP = 0; axi_RDATA = 0;
                prev_err = 0; prev_busy = 0;
            end else begin
                axi_ARREADY = (ar_wait >= arready_delay);
                if (r_active && (!gap_mode || gap_phase)) begin
                    if (!beat_pushed) begin
                        cur_data = $urandom;
                        if (r_burst == 1 && rlast_early >= 0) cur_last = (beat_idx == rlast_early);
                        else cur_last = (beat_idx == BL - 1);
                        cur_resp = (run_beat == err_beat) ? 2'b10 : 2'b00;
                        exp_r.push_back({cur_last, cur_data});
                        beat_pushed = 1;
                    end
                    axi_RVALID = 1; axi_RDATA = cur_data; axi_RLAST = cur_last; axi_RRESP = cur_resp;
                end else begin
                    axi_RVALID = 0; axi_RLAST = 0; axi_RRESP = 0; axi_RDATA = $urandom;
                end
                #1;
                cyc++;
                if (out_shake !== (axi_RVALID & axi_RREADY)) shake_viol++;
                if (out_shake === 1'b1) begin
                    shake_count++;
                    n_checks++;
                    if (exp_r.size() == 0) begin
                        $display("[TB] FAIL r_beat_unexpected: got beat %h, expected no beat", out_rdata);
                    end else begin
                        exp_beat = exp_r.pop_front();
                        if ({out_rlast, out_rdata} !== exp_beat)
                            $display("[TB] FAIL r_beat_data: got %h, expected %h", {out_rlast, out_rdata}, exp_beat);
                        else n_pass++;
                    end
                end
                if (axi_RVALID && axi_RREADY) begin
                    beat_pushed = 0; beat_idx++; run_beat++;
                    if (beat_idx == BL) begin r_active = 0; last_beat_cyc = cyc; end
                end
                if (gap_mode && r_active) gap_phase = !gap_phase;
                if (axi_ARVALID && axi_ARREADY) begin
                    ar_count++; r_burst++;
                    n_checks++;
                    if (exp_ar.size() == 0) begin
                        $display("[TB] FAIL ar_unexpected: got addr %h, expected no request", axi_ARADDR);
                    end else begin
                        exp_addr = exp_ar.pop_front();
                        if (axi_ARADDR !== exp_addr)
                            $display("[TB] FAIL ar_addr: got %h, expected %h", axi_ARADDR, exp_addr);
                        else n_pass++;
                    end
                    r_active = 1; beat_idx = 0; gap_phase = 0; ar_waiting = 0; ar_wait = 0;
                end else if (axi_ARVALID) begin
                    if (ar_waiting && axi_ARADDR !== ar_hold_addr) ar_viol++;
                    if (axi_RREADY) ar_viol++;
                    ar_hold_addr = axi_ARADDR; ar_waiting = 1; ar_wait++;
                end else if (ar_waiting) begin
                    ar_viol++; ar_waiting = 0; ar_wait = 0;
                end
                if (stage_done === 1'b1) begin done_count++; done_cyc = cyc; end
                if (prev_err && !rd_error && prev_busy) err_drop++;
                prev_err = rd_error; prev_busy = stage_busy;
            end
        end
    end

    // Configure the slave for the next fetch and clear the per-run tallies.
    task automatic begin_run(input int delay, input bit gaps, input int ebeat, input int early);
        @(negedge axi_ACLK);
        arready_delay = delay; gap_mode = gaps; err_beat = ebeat; rlast_early = early;
        ar_count = 0; shake_count = 0; done_count = 0; run_beat = 0; r_burst = 0;
        ar_viol = 0; shake_viol = 0; err_drop = 0; last_beat_cyc = 0; done_cyc = 0;
    endtask

    // Raise stage_start, queue the expected burst addresses, check go->ARVALID.
    task automatic start_fetch(input logic [31:0] base);
        logic [31:0] aligned;
        @(negedge axi_ACLK);
        aligned = base & ~32'h3F;
        for (int i = 0; i < BURSTS; i++) exp_ar.push_back(aligned + 32'(i * BL * 4));
        base_addr = base;
        stage_start = 1;
        @(negedge axi_ACLK);
        #2;
        n_checks++;
        if ({axi_ARVALID, stage_busy, rd_error} !== 3'b110)
            $display("[TB] FAIL go_latency: got arvalid/busy/err %b, expected 110", {axi_ARVALID, stage_busy, rd_error});
        else n_pass++;
        stage_start = 0;
    endtask

    // Wait (bounded) for stage_done, then let the FSM settle back in IDLE.
    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done_count == 0 && i < 3000) begin @(negedge axi_ACLK); i++; end
        n_checks++;
        if (done_count == 0) $display("[TB] FAIL %s_timeout: got no stage_done, expected one within 3000 cycles", tag);
        else n_pass++;
        repeat (3) @(negedge axi_ACLK);
        #3;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({axi_ARVALID, axi_RREADY, stage_busy, stage_done, rd_error, out_shake} !== 6'b0 || axi_ARADDR !== 32'h0)
            $display("[TB] FAIL reset_outputs: got %b addr %h, expected 000000 addr 0",
                     {axi_ARVALID, axi_RREADY, stage_busy, stage_done, rd_error, out_shake}, axi_ARADDR);
        else n_pass++;
        n_checks++;
        if ({axi_ARLEN, axi_ARSIZE, axi_ARBURST} !== {8'd15, 3'b010, 2'b01})
            $display("[TB] FAIL ar_constants: got len %0d size %b burst %b, expected 15 010 01", axi_ARLEN, axi_ARSIZE, axi_ARBURST);
        else n_pass++;
        @(negedge axi_ACLK);
        #3 axi_ARESETN = 1;
    endtask

    task automatic test_basic();
        begin_run(0, 0, -1, -1);
        start_fetch(32'h1000);
        wait_done("basic");
        n_checks++;
        if (ar_count !== BURSTS) $display("[TB] FAIL basic_ar_count: got %0d, expected %0d", ar_count, BURSTS);
        else n_pass++;
        n_checks++;
        if (shake_count !== BEATS) $display("[TB] FAIL basic_shakes: got %0d, expected %0d", shake_count, BEATS);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("[TB] FAIL basic_done_count: got %0d, expected 1", done_count);
        else n_pass++;
        n_checks++;
        if (done_cyc - last_beat_cyc !== 1) $display("[TB] FAIL basic_done_latency: got %0d, expected 1", done_cyc - last_beat_cyc);
        else n_pass++;
        n_checks++;
        if ({rd_error, stage_busy} !== 2'b00) $display("[TB] FAIL basic_final_flags: got err/busy %b, expected 00", {rd_error, stage_busy});
        else n_pass++;
        n_checks++;
        if (exp_ar.size() + exp_r.size() + shake_viol + ar_viol !== 0)
            $display("[TB] FAIL basic_leftovers: got %0d, expected 0", exp_ar.size() + exp_r.size() + shake_viol + ar_viol);
        else n_pass++;
    endtask

    task automatic test_arready_delay();
        begin_run(5, 0, -1, -1);
        start_fetch(32'h2000);
        wait_done("ardelay");
        n_checks++;
        if (ar_viol !== 0) $display("[TB] FAIL ardelay_hold: got %0d violations, expected 0", ar_viol);
        else n_pass++;
        n_checks++;
        if (ar_count !== BURSTS || shake_count !== BEATS)
            $display("[TB] FAIL ardelay_counts: got ar %0d beats %0d, expected %0d %0d", ar_count, shake_count, BURSTS, BEATS);
        else n_pass++;
        arready_delay = 0;
    endtask

    task automatic test_rvalid_gaps();
        begin_run(0, 1, -1, -1);
        start_fetch(32'h3000);
        wait_done("gaps");
        n_checks++;
        if (shake_count !== BEATS) $display("[TB] FAIL gaps_shakes: got %0d, expected %0d", shake_count, BEATS);
        else n_pass++;
        n_checks++;
        if (shake_viol !== 0) $display("[TB] FAIL gaps_shake_match: got %0d violations, expected 0", shake_viol);
        else n_pass++;
        gap_mode = 0;
    endtask

    task automatic test_rresp_error();
        begin_run(0, 0, 7, -1);
        start_fetch(32'h4000);
        wait_done("rresp");
        n_checks++;
        if (rd_error !== 1'b1 || err_drop !== 0)
            $display("[TB] FAIL rresp_sticky: got err %b drops %0d, expected 1 0", rd_error, err_drop);
        else n_pass++;
        n_checks++;
        if (shake_count !== BEATS) $display("[TB] FAIL rresp_shakes: got %0d, expected %0d", shake_count, BEATS);
        else n_pass++;
        begin_run(0, 0, -1, -1);
        start_fetch(32'h4000);
        wait_done("rresp_clear");
        n_checks++;
        if (rd_error !== 1'b0) $display("[TB] FAIL rresp_cleared: got %b, expected 0", rd_error);
        else n_pass++;
    endtask

    task automatic test_rlast_early();
        begin_run(0, 0, -1, 14);
        start_fetch(32'h5000);
        wait_done("rlast");
        n_checks++;
        if (rd_error !== 1'b1) $display("[TB] FAIL rlast_error: got %b, expected 1", rd_error);
        else n_pass++;
        rlast_early = -1;
    endtask

    task automatic test_restart_ignored();
        begin_run(0, 0, -1, -1);
        start_fetch(32'h6000);
        for (int i = 0; i < 500 && shake_count < 10; i++) @(negedge axi_ACLK);
        stage_start = 1;
        @(negedge axi_ACLK);
        stage_start = 0;
        wait_done("restart");
        repeat (5) @(negedge axi_ACLK);
        #3;
        n_checks++;
        if (ar_count !== BURSTS || done_count !== 1 || stage_busy !== 1'b0)
            $display("[TB] FAIL restart_ignored: got ar %0d done %0d busy %b, expected %0d 1 0", ar_count, done_count, stage_busy, BURSTS);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        begin_run(0, 0, -1, -1);
        start_fetch(32'h7000);
        for (int i = 0; i < 500 && shake_count < 20; i++) @(negedge axi_ACLK);
        #3 axi_ARESETN = 0;
        #1;
        n_checks++;
        if ({axi_ARVALID, axi_RREADY, stage_busy, stage_done, rd_error, out_shake} !== 6'b0 || axi_ARADDR !== 32'h0)
            $display("[TB] FAIL reset_mid_outputs: got %b addr %h, expected 000000 addr 0",
                     {axi_ARVALID, axi_RREADY, stage_busy, stage_done, rd_error, out_shake}, axi_ARADDR);
        else n_pass++;
        repeat (2) @(negedge axi_ACLK);
        #3 axi_ARESETN = 1;
        begin_run(0, 0, -1, -1);
        start_fetch(32'h7000);
        wait_done("reset_refetch");
        n_checks++;
        if (ar_count !== BURSTS || shake_count !== BEATS || exp_ar.size() !== 0)
            $display("[TB] FAIL reset_refetch: got ar %0d beats %0d, expected %0d %0d", ar_count, shake_count, BURSTS, BEATS);
        else n_pass++;
    endtask

    task automatic test_unaligned_base();
        begin_run(0, 0, -1, -1);
        start_fetch(32'h1023);
        wait_done("unaligned");
        n_checks++;
        if (ar_count !== BURSTS || exp_ar.size() !== 0)
            $display("[TB] FAIL unaligned_ars: got %0d issued, %0d pending, expected %0d 0", ar_count, exp_ar.size(), BURSTS);
        else n_pass++;
    endtask

    initial begin
        $display("[TB] tb_axi_rd_burst_master starting");
        test_reset();
        test_basic();
        test_arready_delay();
        test_rvalid_gaps();
        test_rresp_error();
        test_rlast_early();
        test_restart_ignored();
        test_reset_mid();
        test_unaligned_base();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
